// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S constants and types for i2s_tx / i2s_rx
//
// Contents:
//   I2S_DATA_WIDTH  default bits per channel sample
//   i2s_chan_t      channel select as carried on lrclk (CH_LEFT=0, CH_RIGHT=1)
//   i2s_rx_state_t  receiver framing state (RX_SYNC, RX_RECEIVE)
`timescale 1ns/1ps

package i2s_pkg;

    localparam int I2S_DATA_WIDTH = 16;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_chan_t;

    typedef enum logic [0:0] {
        RX_SYNC    = 1'b0,
        RX_RECEIVE = 1'b1
    } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_sync.sv
// rtl/i2s_rx_sync.sv - pin synchronizer and sclk rising-edge detector for i2s_rx
//
// Ports:
//   clk, rst      core clock, asynchronous active-high reset
//   sclk, lrclk,  asynchronous I2S pins
//   sdata
//   sclk_rise     one-clk pulse on a synchronized sclk 0->1 transition
//   lr_s, sd_s    lrclk / sdata taken from the same stage as the sclk edge
`timescale 1ns/1ps

module i2s_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic lrclk,
    input  logic sdata,
    output logic sclk_rise,
    output logic lr_s,
    output logic sd_s
);

    logic [SYNC_STAGES-1:0] sclk_pipe;
    logic [SYNC_STAGES-1:0] lr_pipe;
    logic [SYNC_STAGES-1:0] sd_pipe;
    logic                   sclk_last;

    // All three pins share the same depth so lrclk/sdata seen at a sclk_rise
    // are the values present when the pin-level sclk rose.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_pipe <= '0;
            lr_pipe   <= '0;
            sd_pipe   <= '0;
            sclk_last <= 1'b0;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
            lr_pipe   <= {lr_pipe[SYNC_STAGES-2:0], lrclk};
            sd_pipe   <= {sd_pipe[SYNC_STAGES-2:0], sdata};
            sclk_last <= sclk_pipe[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_pipe[SYNC_STAGES-1] & ~sclk_last;
    assign lr_s      = lr_pipe[SYNC_STAGES-1];
    assign sd_s      = sd_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - slave-mode I2S receiver delivering left/right sample pairs
//
// Ports:
//   clk, rst       core clock (clk_114), asynchronous active-high reset
//   sclk, lrclk,   externally driven I2S bus, asynchronous to clk
//   sdata
//   left_chan      last complete left sample (MSB-aligned, truncated/zero-padded)
//   right_chan     last complete right sample
//   sample_valid   one-clk pulse when left_chan/right_chan update together
//   frame_err      (I2S_RX_ERRSTAT_EN) one-clk pulse for a word of wrong length
//   err_count      (I2S_RX_ERRSTAT_EN) saturating count of frame_err pulses
//
// Build option: define I2S_RX_ERRSTAT_EN to add frame_err / err_count.
`timescale 1ns/1ps

module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = I2S_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] left_chan,
    output logic [DATA_WIDTH-1:0] right_chan,
`ifdef I2S_RX_ERRSTAT_EN
    output logic                  frame_err,
    output logic [7:0]            err_count,
`endif
    output logic                  sample_valid
);

    localparam logic [0:0] ST_SYNC    = RX_SYNC;
    localparam logic [0:0] ST_RECEIVE = RX_RECEIVE;

    localparam int                    CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MSB_ONE  = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

    logic                  sclk_rise;
    logic                  lr_s;
    logic                  sd_s;

    logic [0:0]            state;
    logic                  lr_prev;
    logic                  lr_seen;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] shift;
    i2s_chan_t             chan;
    logic [DATA_WIDTH-1:0] left_hold;
    logic                  left_ok;
    logic [DATA_WIDTH-1:0] right_word;
    logic                  pair_pend;

    logic                  lr_edge;
    logic [DATA_WIDTH-1:0] bit_mask;
    logic [DATA_WIDTH-1:0] shift_wr;

    i2s_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .lrclk     (lrclk),
        .sdata     (sdata),
        .sclk_rise (sclk_rise),
        .lr_s      (lr_s),
        .sd_s      (sd_s)
    );

    // lr_seen masks the first sample after reset so a bus idling with
    // lrclk high is not mistaken for a channel change.
    assign lr_edge  = lr_seen && (lr_s != lr_prev);

    // Current bit merged into the word; bits past DATA_WIDTH are dropped,
    // which keeps the MSBs of an over-long word.
    assign bit_mask = (cnt < CNT_MAX && sd_s) ? (MSB_ONE >> cnt) : '0;
    assign shift_wr = shift | bit_mask;

`ifdef I2S_RX_ERRSTAT_EN
    logic word_len_err;
    logic err_pend;

    // The edge bit itself is the last bit, so a correct word ends at cnt = DATA_WIDTH-1.
    assign word_len_err = (cnt != CNT_W'(DATA_WIDTH - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_SYNC;
            lr_prev      <= 1'b0;
            lr_seen      <= 1'b0;
            cnt          <= '0;
            shift        <= '0;
            chan         <= CH_LEFT;
            left_hold    <= '0;
            left_ok      <= 1'b0;
            right_word   <= '0;
            pair_pend    <= 1'b0;
            left_chan    <= '0;
            right_chan   <= '0;
            sample_valid <= 1'b0;
`ifdef I2S_RX_ERRSTAT_EN
            err_pend     <= 1'b0;
`endif
        end else begin
            pair_pend    <= 1'b0;
            sample_valid <= 1'b0;
`ifdef I2S_RX_ERRSTAT_EN
            err_pend     <= 1'b0;
`endif

            // Both outputs load in the same cycle so a pair is never torn.
            if (pair_pend) begin
                left_chan    <= left_hold;
                right_chan   <= right_word;
                sample_valid <= 1'b1;
            end

            if (sclk_rise) begin
                lr_prev <= lr_s;
                lr_seen <= 1'b1;

                case (state)
                    ST_SYNC: begin
                        // The word in flight before the first edge is partial.
                        if (lr_edge) begin
                            state <= ST_RECEIVE;
                            cnt   <= '0;
                            shift <= '0;
                            chan  <= i2s_chan_t'(lr_s);
                        end
                    end

                    default: begin
                        if (lr_edge) begin
                            if (chan == CH_LEFT) begin
                                left_hold <= shift_wr;
                                left_ok   <= 1'b1;
                            end else if (left_ok) begin
                                right_word <= shift_wr;
                                pair_pend  <= 1'b1;
                                left_ok    <= 1'b0;
                            end
`ifdef I2S_RX_ERRSTAT_EN
                            err_pend <= word_len_err;
`endif
                            cnt   <= '0;
                            shift <= '0;
                            chan  <= i2s_chan_t'(lr_s);
                        end else begin
                            shift <= shift_wr;
                            if (cnt < CNT_MAX) begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef I2S_RX_ERRSTAT_EN
    // Delayed to line up with the sample_valid (or discard) cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            err_count <= 8'd0;
        end else begin
            frame_err <= err_pend;
            if (err_pend && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`endif

endmodule
